// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction encoder: format codes, field positions, FSM states.
// No logic; constants and types only.
// Not applicable.
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_ILL = 2'b11
  } fmt_e;

  // Decode path treats this opcode as a special match, so the writer must never emit it.
  localparam logic [5:0] RESERVED_OPCODE = 6'b11_1111;

  // Bit positions inside the 32-bit instruction word.
  localparam int OP_MSB    = 31;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENCODE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_REJECT = 3'd3,
    ST_FULL   = 3'd4
  } state_e;

  // Field bundle captured at the input handshake.
  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
  } fields_t;

endpackage

// File: rtl/mips_field_packer.sv
// Packs R/I/J instruction fields into a 32-bit MIPS word and flags illegal bundles.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the outputs.
module mips_field_packer
  import mips_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the layout by format; fields not used by that format are ignored.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OP_MSB -: 6] = opcode;
    case (fmt)
      FMT_R: begin
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[RD_LSB +: 5]    = rd;
        word[SHAMT_LSB +: 5] = shamt;
        word[0 +: 6]         = funct;
      end
      FMT_I: begin
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        word[0 +: 16]     = imm16;
      end
      FMT_J: begin
        word[0 +: 26] = target26;
      end
      default: illegal = 1'b1;
    endcase
    if (opcode == RESERVED_OPCODE) illegal = 1'b1;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Accepts instruction field bundles and writes packed words sequentially into instruction memory.
// Latency: handshake in cycle N gives wr_en in cycle N+2; one bundle every 3 cycles.
// Backpressure: in_ready is low while a bundle is in flight, when full, or while clear is asserted.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  state_e              state, state_nxt;
  fields_t             hold;
  logic                rdy_q;
  logic                accept;
  logic [31:0]         pk_word;
  logic                pk_illegal;
  logic [ADDR_W:0]     count_inc;
  logic                reach_max;

  // clear takes priority over a same-cycle bundle, so it masks ready directly.
  assign in_ready  = rdy_q & ~clear;
  assign accept    = in_valid & in_ready;
  assign count_inc = count + 1'b1;
  assign reach_max = (count_inc == (ADDR_W+1)'(MAX_WORDS));

  mips_field_packer u_packer (
    .fmt      (hold.fmt),
    .opcode   (hold.opcode),
    .rs       (hold.rs),
    .rt       (hold.rt),
    .rd       (hold.rd),
    .shamt    (hold.shamt),
    .funct    (hold.funct),
    .imm16    (hold.imm16),
    .target26 (hold.target26),
    .word     (pk_word),
    .illegal  (pk_illegal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!clear && accept) state_nxt = ST_ENCODE;
      ST_ENCODE: state_nxt = pk_illegal ? ST_REJECT : ST_WRITE;
      ST_WRITE:  state_nxt = reach_max ? ST_FULL : ST_IDLE;
      ST_REJECT: state_nxt = ST_IDLE;
      ST_FULL:   if (clear) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, registered outputs and address counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold    <= '0;
      rdy_q   <= 1'b1;
      wr_en   <= 1'b0;
      wr_addr <= ADDR_W'(BASE_ADDR);
      wr_data <= '0;
      err     <= 1'b0;
      full    <= 1'b0;
      count   <= '0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE, ST_FULL: begin
          if (clear) begin
            count   <= '0;
            full    <= 1'b0;
            wr_addr <= ADDR_W'(BASE_ADDR);
            rdy_q   <= 1'b1;
          end else if (accept) begin
            hold  <= '{fmt: fmt, opcode: opcode, rs: rs, rt: rt, rd: rd,
                       shamt: shamt, funct: funct, imm16: imm16, target26: target26};
            rdy_q <= 1'b0;
          end
        end
        ST_ENCODE: begin
          if (pk_illegal) begin
            err <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= pk_word;
          end
        end
        ST_WRITE: begin
          count   <= count_inc;
          wr_addr <= ADDR_W'(BASE_ADDR) + count_inc[ADDR_W-1:0];
          if (reach_max) full  <= 1'b1;
          else           rdy_q <= 1'b1;
        end
        ST_REJECT: rdy_q <= 1'b1;
        default:   rdy_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with a write scoreboard.
// Checks latency, packing, reject handling, fill/clear, collision and mid-flight reset.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_mips_instr_encoder;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst_n, clear, in_valid, in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm16;
  logic [25:0]       target26;
  logic              wr_en, err, full;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected writes: {addr, data}
  logic [ADDR_W+31:0] exp_q[$];

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .target26(target26), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+31:32]));
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic scramble();
    fmt = 2'($urandom); opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
    imm16 = 16'($urandom); target26 = 26'($urandom);
  endtask

  // Drives one bundle and checks the ENCODE / WRITE-or-REJECT / next-IDLE cycles.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                      input bit legal, input logic [31:0] exp_data,
                      input int exp_cnt, input bit exp_full);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm16 = im; target26 = tg; in_valid = 1'b1;
    if (legal) exp_q.push_back({ADDR_W'(BASE_ADDR + exp_cnt - 1), exp_data});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    @(negedge clk);
    check("encode_wr_en", 32'(wr_en), 32'd0);
    check("encode_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("n2_wr_en", 32'(wr_en), 32'(legal));
    check("n2_err", 32'(err), 32'(!legal));
    @(negedge clk);
    check("n3_wr_en", 32'(wr_en), 32'd0);
    check("n3_err", 32'(err), 32'd0);
    check("n3_count", 32'(count), 32'(exp_cnt));
    check("n3_full", 32'(full), 32'(exp_full));
    check("n3_in_ready", 32'(in_ready), 32'(!exp_full));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'(BASE_ADDR));
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // R, I, J packing
    send(2'b00, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h1234, 26'h3FF_FFFF, 1'b1, 32'h012A4020, 1, 1'b0);
    send(2'b01, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h155_5555, 1'b1, 32'h20080005, 2, 1'b0);
    send(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010, 1'b1, 32'h08000010, 3, 1'b0);

    // Reserved opcode and illegal format
    send(2'b01, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0006, 26'h0, 1'b0, 32'h0, 3, 1'b0);
    send(2'b11, 6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0006, 26'h7, 1'b0, 32'h0, 3, 1'b0);

    // Clear collides with a valid bundle in IDLE
    @(negedge clk);
    fmt = 2'b00; opcode = 6'h00; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h21;
    clear = 1'b1; in_valid = 1'b1;
    #1 check("coll_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("coll_no_wr", 32'(wr_en), 32'd0);
    end
    check("coll_count", 32'(count), 32'd0);
    check("coll_wr_addr", 32'(wr_addr), 32'(BASE_ADDR));
    check("coll_in_ready_back", 32'(in_ready), 32'd1);

    // Fill to MAX_WORDS
    for (int i = 1; i <= MAX_WORDS; i++)
      send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'(i), 1'b1,
           32'h08000000 | 32'(i), i, i == MAX_WORDS);

    // A fifth bundle must not be accepted while full
    @(negedge clk);
    fmt = 2'b10; opcode = 6'h02; target26 = 26'h5; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_no_wr", 32'(wr_en), 32'd0);
    end
    check("full_count", 32'(count), 32'(MAX_WORDS));
    in_valid = 1'b0;

    // Clear from FULL
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr_full", 32'(full), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_wr_addr", 32'(wr_addr), 32'(BASE_ADDR));
    check("clr_in_ready", 32'(in_ready), 32'd1);
    send(2'b01, 6'h0D, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hBEEF, 26'h0, 1'b1, 32'h3485BEEF, 1, 1'b0);

    // Reset during ENCODE discards the bundle
    @(negedge clk);
    fmt = 2'b00; opcode = 6'h00; rs = 5'd3; rt = 5'd4; rd = 5'd5; shamt = 5'd2; funct = 6'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'(BASE_ADDR));
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_wr", 32'(wr_en), 32'd0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Writer-side counterpart to the instruction decode path: accepts instruction fields (R/I/J format) over a valid/ready handshake and packs them into 32-bit MIPS instruction words.
- Writes the packed words sequentially into instruction memory through a simple write port.
- Used by the program loader and CPU-level benches to build instruction images that the decode path consumes.
- Rejects the reserved all-ones opcode (6'b11_1111), which the decode path treats as a special match.

Parameters:
ADDR_W, 8, word-address width of the instruction memory write port
BASE_ADDR, 0, first word address written after reset or clear
MAX_WORDS, 256, capacity in words; must be <= 2**ADDR_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous restart of the address counter, sampled only in IDLE/FULL
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
fmt  input  2  00=R, 01=I, 10=J, 11=illegal
opcode  input  6  opcode field
rs  input  5  R/I source register
rt  input  5  R/I target register
rd  input  5  R destination register
shamt  input  5  R shift amount
funct  input  6  R function code
imm16  input  16  I immediate
target26  input  26  J jump target
wr_en  output  1  one-cycle memory write strobe
wr_addr  output  ADDR_W  word address of the write
wr_data  output  32  packed instruction word
err  output  1  one-cycle pulse on a rejected bundle
full  output  1  MAX_WORDS words written
count  output  ADDR_W+1  words written since reset/clear

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, err=0, full=0, count=0.
- Reset mid-operation: a bundle captured but not yet written is discarded with no write.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches all fields into a holding register and moves to ENCODE.
  - ENCODE: in_ready=0. Builds the word combinationally from the held fields, registers it, then goes to WRITE (legal) or REJECT (illegal).
  - WRITE: wr_en=1 for exactly one cycle, with wr_addr=BASE_ADDR+count and wr_data=the registered word. count increments. Goes to FULL if count reaches MAX_WORDS, else IDLE.
  - REJECT: err=1 for one cycle. No write, count unchanged. Returns to IDLE.
  - FULL: in_ready=0, full=1. Only clear or reset leaves this state.
- Packing:
  - R format: {opcode, rs, rt, rd, shamt, funct}.
  - I format: {opcode, rs, rt, imm16}.
  - J format: {opcode, target26}.
  - Unused input fields are ignored.
- Illegal bundle: fmt=11, or opcode=6'b11_1111 in any format.
- Latency: handshake at cycle N gives wr_en at cycle N+2. The next handshake is possible at N+3, so throughput is one word per 3 cycles.
- in_ready is registered and independent of in_valid. The fields must stay stable only during the handshake cycle.
- clear in IDLE/FULL: count=0, full=0, wr_addr=BASE_ADDR, state=IDLE on the next cycle. clear in ENCODE/WRITE/REJECT is ignored.
- Simultaneous clear and in_valid in IDLE: clear wins and the bundle is not accepted (in_ready forced to 0 in that cycle).
- Address wrap: wr_addr is computed modulo 2**ADDR_W. It never wraps in practice because FULL stops writes at MAX_WORDS.

Decomposition:
- Shared package mips_pkg:
  - format codes FMT_R/FMT_I/FMT_J/FMT_ILL
  - RESERVED_OPCODE=6'b11_1111
  - field widths and bit positions (OP_MSB=31, RS_LSB=21, RT_LSB=16, RD_LSB=11, SHAMT_LSB=6)
  - state encoding
- Sub-module: mips_field_packer, a purely combinational fmt/fields -> {word, illegal} function. The top level holds the FSM, holding register and address counter.

Test Plan:
- R pack: fmt=00, opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=6'h20 -> wr_en at N+2, wr_addr=0, wr_data=32'h012A4020, count=1.
- I pack then J pack: I fmt, opcode=6'h08, rs=0, rt=8, imm16=16'h0005; then J fmt, opcode=6'h02, target26=26'h0000010 -> wr_data=32'h20080005 at addr 0, then 32'h08000010 at addr 1.
- Reserved opcode: fmt=01, opcode=6'b11_1111 -> err pulse 1 cycle at N+2, wr_en stays 0, count unchanged, in_ready back to 1 at N+3.
- Illegal format: fmt=11 with any fields -> err pulse, no write.
- Fill and clear (MAX_WORDS=4): four legal bundles -> full=1, in_ready=0, and a fifth in_valid is not accepted; then clear -> full=0, count=0, and the next write goes to BASE_ADDR.
- Reset mid-flight: assert rst_n=0 in the ENCODE cycle -> no wr_en, all outputs at their reset values the next cycle.
- Clear collision: clear=1 together with in_valid=1 in IDLE -> no handshake, count=0.
